// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among SRC_NUM producers, with fill-level throttling.
// Optional drop counter outputs are enabled by defining FIFO_WR_ARB_DROP_CNT_EN.
module fifo_wr_arb #(
    parameter int SRC_NUM = 4,
    parameter int DATA_W  = 10,
    parameter int USEDW_W = 6,
    parameter int FULL_TH = 61,
    parameter int BURST   = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [SRC_NUM-1:0]          req,
    input  logic [SRC_NUM*DATA_W-1:0]   src_data,
    input  logic [SRC_NUM-1:0]          src_vld,
    output logic [SRC_NUM-1:0]          grant,
    input  logic [USEDW_W-1:0]          wrusedw,
    output logic                        fifo_wr,
    output logic [DATA_W-1:0]           fifo_data,
`ifdef FIFO_WR_ARB_DROP_CNT_EN
    output logic [15:0]                 drop_cnt,
    output logic                        drop_err,
`endif
    output logic                        busy
);

    localparam int IDX_W = (SRC_NUM > 1) ? $clog2(SRC_NUM) : 1;
    localparam logic [IDX_W:0]   SRC_NUM_V = (IDX_W+1)'(SRC_NUM);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(SRC_NUM - 1);
    localparam logic [USEDW_W:0] FULL_TH_V = (USEDW_W+1)'(FULL_TH);
    localparam logic [7:0]       BURST_V   = 8'(BURST);
    localparam logic [SRC_NUM-1:0] ONE_HOT0 = SRC_NUM'(1);

    typedef enum logic [1:0] {IDLE, GRANT, PAUSE} state_t;

    state_t               state_reg, state_next;
    logic [SRC_NUM-1:0]   grant_reg, grant_next;
    logic                 fifo_wr_reg, fifo_wr_next;
    logic [DATA_W-1:0]    fifo_data_reg, fifo_data_next;
    logic [7:0]           cnt_reg, cnt_next;
    logic [IDX_W-1:0]     last_reg, last_next;
    logic [IDX_W-1:0]     cur_reg, cur_next;

    logic [USEDW_W:0]     fill;
    logic                 space_ok;
    logic [SRC_NUM-1:0]   accept_vec;
    logic                 accept;
    logic [DATA_W-1:0]    accept_data;
    logic [DATA_W-1:0]    masked_data [SRC_NUM];
    logic [IDX_W-1:0]     cand [SRC_NUM];
    logic                 found;
    logic [IDX_W-1:0]     win;
    logic [7:0]           cnt_inc;

    // The in-flight write is counted so the threshold sees the word about to land.
    assign fill       = {1'b0, wrusedw} + {{USEDW_W{1'b0}}, fifo_wr_reg};
    assign space_ok   = fill < FULL_TH_V;
    assign accept_vec = grant_reg & src_vld;
    assign accept     = |accept_vec;
    assign cnt_inc    = cnt_reg + 8'd1;

    generate
        for (genvar gi = 0; gi < SRC_NUM; gi++) begin : g_src
            logic [IDX_W:0] sum;
            assign masked_data[gi] = accept_vec[gi] ? src_data[gi*DATA_W +: DATA_W] : '0;
            assign sum       = {1'b0, last_reg} + (IDX_W+1)'(gi + 1);
            assign cand[gi]  = (sum >= SRC_NUM_V) ? IDX_W'(sum - SRC_NUM_V) : IDX_W'(sum);
        end
    endgenerate

    always_comb begin
        accept_data = '0;
        for (int k = 0; k < SRC_NUM; k++) begin
            accept_data = accept_data | masked_data[k];
        end
    end

    // cand[] walks from last+1 around the ring, so the first hit is the round-robin winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < SRC_NUM; k++) begin
            if (!found && req[cand[k]]) begin
                found = 1'b1;
                win   = cand[k];
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        cnt_next       = cnt_reg;
        last_next      = last_reg;
        cur_next       = cur_reg;
        fifo_wr_next   = accept;
        fifo_data_next = accept ? accept_data : fifo_data_reg;
        case (state_reg)
            IDLE: begin
                grant_next = '0;
                if (found && space_ok) begin
                    grant_next = ONE_HOT0 << win;
                    cur_next   = win;
                    cnt_next   = '0;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (accept) cnt_next = cnt_inc;
                if ((accept && (cnt_inc == BURST_V)) || !req[cur_reg]) begin
                    state_next = IDLE;
                    grant_next = '0;
                    last_next  = cur_reg;
                end else if (!space_ok) begin
                    state_next = PAUSE;
                    grant_next = '0;
                end
            end
            PAUSE: begin
                grant_next = '0;
                if (!req[cur_reg]) begin
                    state_next = IDLE;
                    last_next  = cur_reg;
                end else if (space_ok) begin
                    state_next = GRANT;
                    grant_next = ONE_HOT0 << cur_reg;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            fifo_wr_reg   <= 1'b0;
            fifo_data_reg <= '0;
            cnt_reg       <= '0;
            last_reg      <= LAST_RST;
            cur_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            fifo_wr_reg   <= fifo_wr_next;
            fifo_data_reg <= fifo_data_next;
            cnt_reg       <= cnt_next;
            last_reg      <= last_next;
            cur_reg       <= cur_next;
        end
    end

    assign grant     = grant_reg;
    assign fifo_wr   = fifo_wr_reg;
    assign fifo_data = fifo_data_reg;
    assign busy      = (state_reg != IDLE);

`ifdef FIFO_WR_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_reg;
    logic        drop_err_reg;
    logic        drop;

    assign drop = |(src_vld & ~grant_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
            drop_err_reg <= 1'b0;
        end else if (drop) begin
            if (drop_cnt_reg != 16'hFFFF) drop_cnt_reg <= drop_cnt_reg + 16'd1;
            drop_err_reg <= 1'b1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
    assign drop_err = drop_err_reg;
`endif

endmodule
